// File: rtl/hex_word_emitter_pkg.sv
// Shared constants for the hex word emitter: FSM encodings and default widths.
package hex_word_emitter_pkg;

  localparam int unsigned DEF_WORDW = 16;
  localparam int unsigned DEF_ADDRW = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_word_emitter_if.sv
// Print-request and character-write handshake between a parent and the emitter.
interface hex_word_emitter_if
  import hex_word_emitter_pkg::*;
#(
  parameter int unsigned WORDW = DEF_WORDW,
  parameter int unsigned ADDRW = DEF_ADDRW
);

  logic             start;
  logic [WORDW-1:0] value;
  logic [ADDRW-1:0] base_addr;
  logic             wr_en;
  logic             wr_ready;
  logic [3:0]       nibble_out;
  logic [ADDRW-1:0] wr_addr;
  logic             busy;
  logic             done;

  // Requester side: issues print requests and accepts character writes.
  modport master (
    output start, value, base_addr, wr_ready,
    input  wr_en, nibble_out, wr_addr, busy, done
  );

  // Emitter side.
  modport slave (
    input  start, value, base_addr, wr_ready,
    output wr_en, nibble_out, wr_addr, busy, done
  );

endinterface

// File: rtl/hex_word_emitter.sv
// Streams a captured word out as hex nibbles, MSB first, each with a text-buffer
// write address that advances by one per accepted write and wraps silently.
module hex_word_emitter
  import hex_word_emitter_pkg::*;
#(
  parameter int unsigned WORDW = DEF_WORDW,
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input logic               clk,
  input logic               rstn,
  hex_word_emitter_if.slave bus
);

  localparam int unsigned NIB      = WORDW / 4;
  localparam int unsigned IDXW     = $clog2(NIB + 1);
  localparam int unsigned LAST_IDX = NIB - 1;

  state_t           state_q, state_d;
  logic [WORDW-1:0] shift_q, shift_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [ADDRW-1:0] addr_q, addr_d;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic; a stalled write leaves every register untouched.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shift_d = bus.value;
          addr_d  = bus.base_addr;
          idx_d   = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.wr_ready) begin
          shift_d = shift_q << 4;
          idx_d   = idx_q + IDXW'(1);
          addr_d  = addr_q + ADDRW'(1);
          if (idx_q == IDXW'(LAST_IDX)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, never on wr_ready or start.
  assign bus.wr_en      = (state_q == ST_EMIT);
  assign bus.busy       = (state_q == ST_EMIT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.nibble_out = shift_q[WORDW-1 -: 4];
  assign bus.wr_addr    = addr_q;

endmodule

// File: tb/tb_hex_word_emitter.sv
// Directed bench for hex_word_emitter: 16-bit and 32-bit instances, hand-computed streams.
module tb_hex_word_emitter;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  hex_word_emitter_if #(.WORDW(16), .ADDRW(11)) bus_a ();
  hex_word_emitter_if #(.WORDW(32), .ADDRW(11)) bus_b ();

  hex_word_emitter #(.WORDW(16), .ADDRW(11)) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_a.slave)
  );

  hex_word_emitter #(.WORDW(32), .ADDRW(11)) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [3:0] nib, input logic [10:0] addr);
    chk({tag, ".wr_en"}, 32'(bus_a.wr_en), 32'd1);
    chk({tag, ".busy"},  32'(bus_a.busy),  32'd1);
    chk({tag, ".done"},  32'(bus_a.done),  32'd0);
    chk({tag, ".nib"},   32'(bus_a.nibble_out), 32'(nib));
    chk({tag, ".addr"},  32'(bus_a.wr_addr),    32'(addr));
  endtask

  task automatic expect_done(input string tag);
    chk({tag, ".done"},  32'(bus_a.done),  32'd1);
    chk({tag, ".wr_en"}, 32'(bus_a.wr_en), 32'd0);
    chk({tag, ".busy"},  32'(bus_a.busy),  32'd0);
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".done"},  32'(bus_a.done),  32'd0);
    chk({tag, ".wr_en"}, 32'(bus_a.wr_en), 32'd0);
    chk({tag, ".busy"},  32'(bus_a.busy),  32'd0);
  endtask

  task automatic expect_wr_b(input string tag, input logic [3:0] nib, input logic [10:0] addr);
    chk({tag, ".wr_en"}, 32'(bus_b.wr_en), 32'd1);
    chk({tag, ".done"},  32'(bus_b.done),  32'd0);
    chk({tag, ".nib"},   32'(bus_b.nibble_out), 32'(nib));
    chk({tag, ".addr"},  32'(bus_b.wr_addr),    32'(addr));
  endtask

  task automatic start_a(input logic [15:0] val, input logic [10:0] base);
    bus_a.start     = 1'b1;
    bus_a.value     = val;
    bus_a.base_addr = base;
    step();
    bus_a.start     = 1'b0;
    bus_a.value     = 16'h0;
    bus_a.base_addr = 11'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    bus_a.start = 1'b0; bus_a.value = 16'h0; bus_a.base_addr = 11'h0; bus_a.wr_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.value = 32'h0; bus_b.base_addr = 11'h0; bus_b.wr_ready = 1'b1;

    // Reset values
    #12;
    expect_idle("rst");
    chk("rst.nib",  32'(bus_a.nibble_out), 32'h0);
    chk("rst.addr", 32'(bus_a.wr_addr),    32'h0);
    chk("rst_b.wr_en", 32'(bus_b.wr_en),   32'd0);
    rstn = 1'b1;
    step();
    step();
    expect_idle("idle0");

    // BEEF at 0A0 with no stalls
    start_a(16'hBEEF, 11'h0A0);
    expect_wr("t1.c1", 4'hB, 11'h0A0);
    step(); expect_wr("t1.c2", 4'hE, 11'h0A1);
    step(); expect_wr("t1.c3", 4'hE, 11'h0A2);
    step(); expect_wr("t1.c4", 4'hF, 11'h0A3);
    step(); expect_done("t1.c5");
    step(); expect_idle("t1.c6");

    // Same print, wr_ready low in cycles 2-4
    start_a(16'hBEEF, 11'h0A0);
    expect_wr("t2.c1", 4'hB, 11'h0A0);
    step(); bus_a.wr_ready = 1'b0; expect_wr("t2.c2", 4'hE, 11'h0A1);
    step(); expect_wr("t2.c3", 4'hE, 11'h0A1);
    step(); expect_wr("t2.c4", 4'hE, 11'h0A1);
    step(); bus_a.wr_ready = 1'b1; expect_wr("t2.c5", 4'hE, 11'h0A1);
    step(); expect_wr("t2.c6", 4'hE, 11'h0A2);
    step(); expect_wr("t2.c7", 4'hF, 11'h0A3);
    step(); expect_done("t2.c8");
    step(); expect_idle("t2.c9");

    // Address wrap at the top of the text buffer
    start_a(16'h1234, 11'h7FE);
    expect_wr("t3.c1", 4'h1, 11'h7FE);
    step(); expect_wr("t3.c2", 4'h2, 11'h7FF);
    step(); expect_wr("t3.c3", 4'h3, 11'h000);
    step(); expect_wr("t3.c4", 4'h4, 11'h001);
    step(); expect_done("t3.c5");
    step(); expect_idle("t3.c6");

    // start during EMIT is neither honoured nor queued
    start_a(16'hBEEF, 11'h0A0);
    expect_wr("t4.c1", 4'hB, 11'h0A0);
    step();
    bus_a.start = 1'b1; bus_a.value = 16'h5555; bus_a.base_addr = 11'h300;
    expect_wr("t4.c2", 4'hE, 11'h0A1);
    step();
    bus_a.start = 1'b0; bus_a.value = 16'h0; bus_a.base_addr = 11'h0;
    expect_wr("t4.c3", 4'hE, 11'h0A2);
    step(); expect_wr("t4.c4", 4'hF, 11'h0A3);
    step(); expect_done("t4.c5");
    step(); expect_idle("t4.c6");
    step(); expect_idle("t4.c7");
    step(); expect_idle("t4.c8");

    // Asynchronous reset mid-print, then a fresh print
    start_a(16'hBEEF, 11'h0A0);
    expect_wr("t5.c1", 4'hB, 11'h0A0);
    step(); expect_wr("t5.c2", 4'hE, 11'h0A1);
    #2 rstn = 1'b0;
    #1;
    expect_idle("t5.rst");
    chk("t5.rst.nib",  32'(bus_a.nibble_out), 32'h0);
    chk("t5.rst.addr", 32'(bus_a.wr_addr),    32'h0);
    step();
    #2 rstn = 1'b1;
    step(); expect_idle("t5.rel");
    start_a(16'h00FF, 11'h000);
    expect_wr("t5.p1", 4'h0, 11'h000);
    step(); expect_wr("t5.p2", 4'h0, 11'h001);
    step(); expect_wr("t5.p3", 4'hF, 11'h002);
    step(); expect_wr("t5.p4", 4'hF, 11'h003);
    step(); expect_done("t5.p5");
    step(); expect_idle("t5.p6");

    // 32-bit word, second start in the first IDLE cycle after done
    bus_b.start = 1'b1; bus_b.value = 32'hDEADBEEF; bus_b.base_addr = 11'h100;
    step();
    bus_b.start = 1'b0; bus_b.value = 32'h0; bus_b.base_addr = 11'h0;
    expect_wr_b("t6.c1", 4'hD, 11'h100);
    step(); expect_wr_b("t6.c2", 4'hE, 11'h101);
    step(); expect_wr_b("t6.c3", 4'hA, 11'h102);
    step(); expect_wr_b("t6.c4", 4'hD, 11'h103);
    step(); expect_wr_b("t6.c5", 4'hB, 11'h104);
    step(); expect_wr_b("t6.c6", 4'hE, 11'h105);
    step(); expect_wr_b("t6.c7", 4'hE, 11'h106);
    step(); expect_wr_b("t6.c8", 4'hF, 11'h107);
    step();
    chk("t6.c9.done",  32'(bus_b.done),  32'd1);
    chk("t6.c9.wr_en", 32'(bus_b.wr_en), 32'd0);
    step();
    chk("t6.c10.done",  32'(bus_b.done),  32'd0);
    chk("t6.c10.wr_en", 32'(bus_b.wr_en), 32'd0);
    bus_b.start = 1'b1; bus_b.value = 32'h0123_4567; bus_b.base_addr = 11'h200;
    step();
    bus_b.start = 1'b0; bus_b.value = 32'h0; bus_b.base_addr = 11'h0;
    expect_wr_b("t6.n1", 4'h0, 11'h200);
    step(); expect_wr_b("t6.n2", 4'h1, 11'h201);
    step(); expect_wr_b("t6.n3", 4'h2, 11'h202);
    for (int i = 0; i < 6; i++) step();
    chk("t6.n.done", 32'(bus_b.done), 32'd1);
    step();
    chk("t6.n.idle", 32'(bus_b.wr_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
